// File: rtl/twofish_pkg.sv
// twofish_pkg: shared constants, FSM state type and rotate helper for the Twofish key schedule
package twofish_pkg;
  localparam logic [31:0] RHO = 32'h01010101;
  localparam int NUM_SUBKEYS = 40;
  localparam int NUM_PAIRS = 20;
  typedef enum logic [2:0] {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, WR_EVEN, WR_ODD, DONE} ks_state_t;
  function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
endpackage

// File: rtl/twofish_key_sched_ctrl_if.sv
// twofish_key_sched_ctrl_if: control, h-datapath and subkey-write bus; TWOFISH_KS_RAM_EN adds rd_addr/rd_data
interface twofish_key_sched_ctrl_if;
  logic start;
  logic [127:0] key;
  logic busy;
  logic done;
  logic [31:0] h_x;
  logic [31:0] h_s0;
  logic [31:0] h_s1;
  logic [31:0] h_y;
  logic sk_we;
  logic [5:0] sk_addr;
  logic [31:0] sk_data;
`ifdef TWOFISH_KS_RAM_EN
  logic [5:0] rd_addr;
  logic [31:0] rd_data;
  modport master (input start, key, h_y, rd_addr, output busy, done, h_x, h_s0, h_s1, sk_we, sk_addr, sk_data, rd_data);
  modport slave (output start, key, h_y, rd_addr, input busy, done, h_x, h_s0, h_s1, sk_we, sk_addr, sk_data, rd_data);
`else
  modport master (input start, key, h_y, output busy, done, h_x, h_s0, h_s1, sk_we, sk_addr, sk_data);
  modport slave (output start, key, h_y, input busy, done, h_x, h_s0, h_s1, sk_we, sk_addr, sk_data);
`endif
endinterface

// File: rtl/twofish_subkey_ram.sv
// twofish_subkey_ram: 40x32 subkey store, one write port, registered read returning 0 past the last index
module twofish_subkey_ram import twofish_pkg::*; (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  input  logic [5:0]  rd_addr,
  output logic [31:0] rd_data
);
  logic [31:0] mem [NUM_SUBKEYS];
  always_ff @(posedge clk) begin
    if (we && addr < 6'(NUM_SUBKEYS)) mem[addr] <= wdata;
    rd_data <= rd_addr < 6'(NUM_SUBKEYS) ? mem[rd_addr] : '0;
  end
endmodule

// File: rtl/twofish_key_sched_ctrl.sv
// twofish_key_sched_ctrl: sequences one shared h datapath to emit K0..K39; TWOFISH_KS_RAM_EN adds an internal subkey store
module twofish_key_sched_ctrl import twofish_pkg::*; #(
  parameter int H_LAT = 1
) (
  input logic clk,
  input logic rst,
  twofish_key_sched_ctrl_if.master bus
);
  localparam int CW = H_LAT > 1 ? $clog2(H_LAT) : 1;
  ks_state_t state, nxt;
  logic [CW-1:0] wcnt;
  logic [4:0] i;
  logic [127:0] key_q;
  logic [31:0] a, b, sum;
  logic last, last_pair;
  // the h request cycle itself counts toward H_LAT, so WAIT_* covers the remaining H_LAT-1 cycles
  assign last = wcnt == CW'(H_LAT - 1);
  assign last_pair = i == 5'(NUM_PAIRS - 1);
  assign sum = a + b;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:          nxt = bus.start ? REQ_A : IDLE;
      REQ_A, WAIT_A: nxt = last ? REQ_B : WAIT_A;
      REQ_B, WAIT_B: nxt = last ? WR_EVEN : WAIT_B;
      WR_EVEN:       nxt = WR_ODD;
      WR_ODD:        nxt = last_pair ? DONE : REQ_A;
      default:       nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = !(state inside {IDLE, DONE});
    bus.done = state == DONE;
    bus.sk_we = state inside {WR_EVEN, WR_ODD};
    bus.sk_addr = state == WR_EVEN ? {i, 1'b0} : state == WR_ODD ? {i, 1'b1} : '0;
    bus.sk_data = state == WR_EVEN ? sum : state == WR_ODD ? rol32(sum + b, 9) : '0;
  end
  // h operands are loaded on the edge entering each REQ state and held through its WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      i <= '0;
      key_q <= '0;
      a <= '0;
      b <= '0;
      bus.h_x <= '0;
      bus.h_s0 <= '0;
      bus.h_s1 <= '0;
    end else begin
      wcnt <= (state inside {REQ_A, WAIT_A, REQ_B, WAIT_B}) && !last ? wcnt + CW'(1) : '0;
      if (state == IDLE && bus.start) begin
        key_q <= bus.key;
        i <= '0;
        bus.h_x <= '0;
        bus.h_s0 <= bus.key[95:64];
        bus.h_s1 <= bus.key[31:0];
      end
      if ((state == REQ_A || state == WAIT_A) && last) begin
        a <= bus.h_y;
        bus.h_x <= RHO * {24'b0, 2'b0, i, 1'b1};
        bus.h_s0 <= key_q[127:96];
        bus.h_s1 <= key_q[63:32];
      end
      if ((state == REQ_B || state == WAIT_B) && last) b <= rol32(bus.h_y, 8);
      if (state == WR_ODD && !last_pair) begin
        i <= i + 5'd1;
        bus.h_x <= RHO * {24'b0, 2'b0, i + 5'd1, 1'b0};
        bus.h_s0 <= key_q[95:64];
        bus.h_s1 <= key_q[31:0];
      end
    end
  end
`ifdef TWOFISH_KS_RAM_EN
  twofish_subkey_ram u_ram (
    .clk(clk),
    .we(bus.sk_we),
    .addr(bus.sk_addr),
    .wdata(bus.sk_data),
    .rd_addr(bus.rd_addr),
    .rd_data(bus.rd_data)
  );
`endif
endmodule

// File: tb/tb_twofish_key_sched_ctrl.sv
// tb_twofish_key_sched_ctrl: real Sbox+MDS h model on H_LAT=1 and H_LAT=3 instances, checked against a subkey reference model
module tb_twofish_key_sched_ctrl;
  localparam logic [63:0] QT [2][4] = '{
    '{64'h817D6F320B59ECA4, 64'hECB81235F4A6709D, 64'hBA5E6D90C8F32471, 64'hD7F4126E9B3085CA},
    '{64'h28BDF76E31940AC5, 64'h1E2B4C376DA5F908, 64'h4C75169A0ED82B3F, 64'hB951C3DE647F208A}};
  localparam logic [7:0] MDS [4][4] = '{
    '{8'h01, 8'hEF, 8'h5B, 8'h5B}, '{8'h5B, 8'hEF, 8'hEF, 8'h01},
    '{8'hEF, 8'h5B, 8'h01, 8'hEF}, '{8'hEF, 8'h01, 8'hEF, 8'h5B}};
  localparam int QI [4] = '{0, 1, 0, 1};
  localparam int QM [4] = '{0, 0, 1, 1};
  localparam int QO [4] = '{1, 0, 1, 0};
  localparam logic [31:0] KZ [4] = '{32'h52C54DDE, 32'h11F0626D, 32'h7CAC9D4A, 32'h4D1B4AAA};

  logic clk, rst, start;
  logic [127:0] key;
  logic [31:0] p1, p2;
  logic [31:0] exp_k [40];
  logic [31:0] got [2][40];
  int wc [2];
  int dc [2];
  int vec, miss;

  twofish_key_sched_ctrl_if b1 ();
  twofish_key_sched_ctrl_if b3 ();
  twofish_key_sched_ctrl #(.H_LAT(1)) d1 (.clk(clk), .rst(rst), .bus(b1.master));
  twofish_key_sched_ctrl #(.H_LAT(3)) d3 (.clk(clk), .rst(rst), .bus(b3.master));

  function automatic logic [3:0] nib(input int s, input int t, input logic [3:0] k);
    logic [63:0] w;
    w = QT[s][t];
    return w[60 - 4 * int'(k) +: 4];
  endfunction
  function automatic logic [7:0] q(input int s, input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2;
    a0 = x[7:4]; b0 = x[3:0];
    a1 = a0 ^ b0; b1 = a0 ^ {b0[0], b0[3:1]} ^ {a0[0], 3'b0};
    a2 = nib(s, 0, a1); b2 = nib(s, 1, b1);
    a1 = a2 ^ b2; b1 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b0};
    return {nib(s, 3, b1), nib(s, 2, a1)};
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] r, x;
    r = 0; x = a;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) r ^= x;
      x = x[7] ? ((x << 1) ^ 8'h69) : (x << 1);
    end
    return r;
  endfunction
  function automatic logic [31:0] h_fn(input logic [31:0] x, input logic [31:0] l1, input logic [31:0] l0);
    logic [7:0] y [4];
    logic [31:0] z;
    for (int j = 0; j < 4; j++)
      y[j] = q(QO[j], q(QM[j], q(QI[j], x[8*j +: 8]) ^ l1[8*j +: 8]) ^ l0[8*j +: 8]);
    z = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) z[8*r +: 8] = z[8*r +: 8] ^ gmul(MDS[r][c], y[c]);
    return z;
  endfunction
  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  assign b1.start = start;
  assign b3.start = start;
  assign b1.key = key;
  assign b3.key = key;
  assign b1.h_y = h_fn(b1.h_x, b1.h_s0, b1.h_s1);
  assign b3.h_y = p2;
  always @(posedge clk) begin
    p1 <= h_fn(b3.h_x, b3.h_s0, b3.h_s1);
    p2 <= p1;
  end
`ifdef TWOFISH_KS_RAM_EN
  logic [5:0] rd_addr;
  assign b1.rd_addr = rd_addr;
  assign b3.rd_addr = rd_addr;
`endif

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model(input logic [127:0] k);
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = h_fn(32'h01010101 * (2 * i), k[95:64], k[31:0]);
      b = rl(h_fn(32'h01010101 * (2 * i + 1), k[127:96], k[63:32]), 8);
      exp_k[2*i] = a + b;
      exp_k[2*i+1] = rl(a + 2 * b, 9);
    end
  endtask

  task automatic chk(input int g, input int n, input logic we, input logic [5:0] a, input logic [31:0] d,
                     input logic bz, input logic dn);
    int hl;
    hl = g ? 3 : 1;
    if (we) begin
      vec++;
      assert (wc[g] < 40 && a === 6'(wc[g]) && d === exp_k[wc[g]] && bz === 1'b1)
      else begin
        miss++;
        $error("FAIL write h%0d #%0d: addr=%0d data=%h busy=%b, want addr=%0d data=%h busy=1",
               hl, wc[g], a, d, bz, wc[g], exp_k[wc[g]]);
      end
      if (wc[g] < 40) got[g][wc[g]] = d;
      wc[g]++;
    end
    if (dn) begin
      vec++;
      assert (dc[g] == 0 && n == 40 * hl + 41 && wc[g] == 40 && bz === 1'b0)
      else begin
        miss++;
        $error("FAIL done h%0d: cycle=%0d writes=%0d busy=%b, want cycle=%0d writes=40 busy=0",
               hl, n, wc[g], bz, 40 * hl + 41);
      end
      dc[g] = n;
    end
  endtask

  task automatic run(input logic [127:0] k, input int restart_at, input int rst_at, input bit chg);
    int run3;
    logic [95:0] h3p;
    model(k);
    wc = '{0, 0};
    dc = '{0, 0};
    @(negedge clk);
    key = k;
    start = 1;
    h3p = {b3.h_x, b3.h_s0, b3.h_s1};
    run3 = 99;
    @(negedge clk);
    start = 0;
    if (chg) key = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 1; n <= 200; n++) begin
      if ({b3.h_x, b3.h_s0, b3.h_s1} !== h3p) begin
        vec++;
        assert (run3 >= 3) else begin
          miss++;
          $error("FAIL h_hold cycle %0d: held %0d cycles, want >= 3", n, run3);
        end
        run3 = 1;
        h3p = {b3.h_x, b3.h_s0, b3.h_s1};
      end else run3++;
      chk(0, n, b1.sk_we, b1.sk_addr, b1.sk_data, b1.busy, b1.done);
      chk(1, n, b3.sk_we, b3.sk_addr, b3.sk_data, b3.busy, b3.done);
      if (rst_at >= 0 && wc[0] == rst_at) break;
      if (dc[0] != 0 && dc[1] != 0) break;
      start = n == restart_at;
      @(negedge clk);
    end
    start = 0;
    if (rst_at >= 0) begin
      rst = 1;
      #1;
      vec++;
      assert ({b1.busy, b1.sk_we, b1.done, b3.busy, b3.sk_we, b3.done} === 6'b0) else begin
        miss++;
        $error("FAIL mid_rst: busy/we/done h1=%b%b%b h3=%b%b%b, want 000 000",
               b1.busy, b1.sk_we, b1.done, b3.busy, b3.sk_we, b3.done);
      end
      @(negedge clk);
      rst = 0;
      repeat (4) begin
        @(negedge clk);
        vec++;
        assert ({b1.busy, b1.done, b3.busy, b3.done} === 4'b0) else begin
          miss++;
          $error("FAIL post_rst: busy/done h1=%b%b h3=%b%b, want 00 00", b1.busy, b1.done, b3.busy, b3.done);
        end
      end
    end else begin
      vec++;
      assert (dc[0] == 81 && dc[1] == 161) else begin
        miss++;
        $error("FAIL sched_end: done cycles %0d/%0d, want 81/161", dc[0], dc[1]);
      end
      @(negedge clk);
      vec++;
      assert ({b1.done, b3.done, b1.busy, b3.busy} === 4'b0) else begin
        miss++;
        $error("FAIL done_pulse: done=%b%b busy=%b%b after done, want 0000", b1.done, b3.done, b1.busy, b3.busy);
      end
    end
  endtask

  task automatic chk_k0(input int g);
    vec++;
    assert (got[g][0] === KZ[0]) else begin
      miss++;
      $error("FAIL k0_zero g%0d: %h, want %h", g, got[g][0], KZ[0]);
    end
  endtask

  initial begin
    vec = 0;
    miss = 0;
    rst = 1;
    start = 0;
    key = '0;
`ifdef TWOFISH_KS_RAM_EN
    rd_addr = '0;
`endif
    repeat (3) @(negedge clk);
    vec++;
    assert ({b1.busy, b1.done, b1.sk_we, b1.sk_addr, b1.sk_data, b1.h_x, b1.h_s0, b1.h_s1} === '0) else begin
      miss++;
      $error("FAIL reset h1: busy=%b done=%b we=%b addr=%0d data=%h hx=%h, want all 0",
             b1.busy, b1.done, b1.sk_we, b1.sk_addr, b1.sk_data, b1.h_x);
    end
    vec++;
    assert ({b3.busy, b3.done, b3.sk_we, b3.sk_addr, b3.sk_data, b3.h_x, b3.h_s0, b3.h_s1} === '0) else begin
      miss++;
      $error("FAIL reset h3: busy=%b done=%b we=%b addr=%0d data=%h hx=%h, want all 0",
             b3.busy, b3.done, b3.sk_we, b3.sk_addr, b3.sk_data, b3.h_x);
    end
    rst = 0;
    @(negedge clk);
    run('0, -1, -1, 0);
    for (int j = 0; j < 4; j++) begin
      vec++;
      assert (got[0][j] === KZ[j]) else begin
        miss++;
        $error("FAIL kzero K%0d: %h, want %h", j, got[0][j], KZ[j]);
      end
    end
    chk_k0(1);
`ifdef TWOFISH_KS_RAM_EN
    for (int j = 0; j < 41; j++) begin
      rd_addr = j < 40 ? 6'(j) : 6'd45;
      @(negedge clk);
      vec++;
      assert (b1.rd_data === (j < 40 ? exp_k[j] : 32'h0) && b3.rd_data === (j < 40 ? exp_k[j] : 32'h0)) else begin
        miss++;
        $error("FAIL ram_rd addr %0d: %h/%h, want %h", rd_addr, b1.rd_data, b3.rd_data, j < 40 ? exp_k[j] : 32'h0);
      end
    end
`endif
    run('0, 10, -1, 0);
    run({$urandom, $urandom, $urandom, $urandom}, -1, 12, 0);
`ifdef TWOFISH_KS_RAM_EN
    rd_addr = 6'd3;
    @(negedge clk);
    vec++;
    assert (b1.rd_data === exp_k[3] && b3.rd_data === exp_k[3]) else begin
      miss++;
      $error("FAIL ram_keep: %h/%h, want %h", b1.rd_data, b3.rd_data, exp_k[3]);
    end
`endif
    run('0, -1, -1, 0);
    chk_k0(0);
    chk_k0(1);
    run({$urandom, $urandom, $urandom, $urandom}, -1, -1, 1);
    repeat (3) run({$urandom, $urandom, $urandom, $urandom}, -1, -1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
